ntsc_sync_gen: RTL and testbench

NTSC_SYNC_GEN -- requirements
Module: ntsc_sync_gen

---
 rtl/ntsc_timing_pkg.sv | 70 +++++++
 rtl/ntsc_tick_div.sv | 30 +++
 rtl/ntsc_sync_gen.sv | 78 +++++++
 tb/tb_ntsc_sync_gen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ntsc_timing_pkg.sv
// NTSC sync generator timing constants, line classification and sync level lookup.
// Build option: define NTSC_EQ_PULSES_EN to give lines 0..2 and 6..8 equalizing pulses;
// without it those lines carry the ordinary horizontal sync.
package ntsc_timing_pkg;

    // Horizontal timing in 0.5 us ticks
    localparam logic [6:0] H_TOTAL      = 7'd127;
    localparam logic [6:0] H_SYNC       = 7'd9;
    localparam logic [6:0] H_ACT_START  = 7'd20;
    localparam logic [6:0] H_ACT_END    = 7'd124;
    localparam logic [6:0] H_HALF       = 7'd63;
    localparam logic [6:0] H_VSYNC_LEN  = 7'd54;
    localparam logic [6:0] H_EQ_LEN     = 7'd5;

    // Vertical timing in lines (progressive 262-line frame)
    localparam logic [8:0] V_TOTAL      = 9'd262;
    localparam logic [8:0] V_ACT_START  = 9'd20;
    localparam logic [8:0] V_ACT_END    = 9'd260;
    localparam logic [8:0] V_SYNC_START = 9'd3;
    localparam logic [8:0] V_SYNC_END   = 9'd5;
    // First equalizing range starts at line 0, so only its end is needed
    localparam logic [8:0] V_EQ1_END    = 9'd2;
    localparam logic [8:0] V_EQ2_START  = 9'd6;
    localparam logic [8:0] V_EQ2_END    = 9'd8;
    // Row prefetch runs one line ahead of the active picture
    localparam logic [8:0] V_FETCH_START = 9'd19;
    localparam logic [8:0] V_FETCH_END   = 9'd258;

    // Composite DAC codes
    localparam logic [2:0] SYNC_LVL  = 3'd0;
    localparam logic [2:0] BLANK_LVL = 3'd1;

`ifdef NTSC_EQ_PULSES_EN
    localparam bit EQ_PULSES_EN = 1'b1;
`else
    localparam bit EQ_PULSES_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        LINE_NORMAL,
        LINE_VSYNC,
        LINE_EQ
    } line_kind_e;

    function automatic line_kind_e classify_line(input logic [8:0] l);
        line_kind_e kind;
        logic       is_eq;
        kind  = LINE_NORMAL;
        is_eq = (l <= V_EQ1_END) || (l >= V_EQ2_START && l <= V_EQ2_END);
        if (l >= V_SYNC_START && l <= V_SYNC_END)
            kind = LINE_VSYNC;
        else if (EQ_PULSES_EN && is_eq)
            kind = LINE_EQ;
        return kind;
    endfunction

    function automatic logic [2:0] sync_level(input logic [8:0] l, input logic [6:0] h);
        logic low;
        low = 1'b0;
        case (classify_line(l))
            LINE_VSYNC: low = (h < H_VSYNC_LEN) ||
                              (h >= H_HALF && h < H_HALF + H_VSYNC_LEN);
            LINE_EQ:    low = (h < H_EQ_LEN) ||
                              (h >= H_HALF && h < H_HALF + H_EQ_LEN);
            default:    low = (h < H_SYNC);
        endcase
        return low ? SYNC_LVL : BLANK_LVL;
    endfunction

endpackage

// File: rtl/ntsc_tick_div.sv
// Divides the system clock down to the 0.5 us timing tick.
// tick is high for the one cycle in which the divider sits at DIV-1.
module ntsc_tick_div
    import ntsc_timing_pkg::*;
#(
    parameter int DIV = 12
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // Free-running 0..DIV-1 counter, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/ntsc_sync_gen.sv
// NTSC composite sync / raster timing generator with line-cache prefetch requests.
// Build option: NTSC_EQ_PULSES_EN adds equalizing pulses on lines 0..2 and 6..8.
// All outputs are registered and follow the (line, hcount) counters by one clock.
module ntsc_sync_gen
    import ntsc_timing_pkg::*;
#(
    parameter int DIV = 12
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    output logic       tick,
    output logic [6:0] hcount,
    output logic [8:0] line,
    output logic       row_enable,
    output logic       vblank,
    output logic [2:0] sync_signal,
    output logic       fetch_req,
    output logic [7:0] fetch_row,
    output logic       frame_start
);

    logic       tick_strobe;
    logic [6:0] h_cnt;
    logic [8:0] l_cnt;
    logic       at_line_start;

    ntsc_tick_div #(.DIV(DIV)) u_tick_div (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .tick  (tick_strobe)
    );

    // Registered tick marks the cycle right after the counters moved
    assign at_line_start = tick && (h_cnt == 7'd0);

    // Raster position counters advance once per timing tick
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            h_cnt <= '0;
            l_cnt <= '0;
        end else if (tick_strobe) begin
            if (h_cnt == H_TOTAL - 7'd1) begin
                h_cnt <= '0;
                l_cnt <= (l_cnt == V_TOTAL - 9'd1) ? 9'd0 : l_cnt + 9'd1;
            end else begin
                h_cnt <= h_cnt + 7'd1;
            end
        end
    end

    // Output stage decodes the current raster position into sync, blanking and fetch strobes
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            tick        <= 1'b0;
            hcount      <= '0;
            line        <= '0;
            row_enable  <= 1'b0;
            vblank      <= 1'b1;
            sync_signal <= BLANK_LVL;
            fetch_req   <= 1'b0;
            fetch_row   <= '0;
            frame_start <= 1'b0;
        end else begin
            tick        <= tick_strobe;
            hcount      <= h_cnt;
            line        <= l_cnt;
            row_enable  <= (l_cnt >= V_ACT_START && l_cnt < V_ACT_END) &&
                           (h_cnt >= H_ACT_START && h_cnt < H_ACT_END);
            vblank      <= !(l_cnt >= V_ACT_START && l_cnt < V_ACT_END);
            sync_signal <= sync_level(l_cnt, h_cnt);
            fetch_req   <= at_line_start && (l_cnt >= V_FETCH_START) && (l_cnt <= V_FETCH_END);
            if (at_line_start && (l_cnt >= V_FETCH_START) && (l_cnt <= V_FETCH_END))
                fetch_row <= 8'(l_cnt - V_FETCH_START);
            frame_start <= at_line_start && (l_cnt == 9'd0);
        end
    end

endmodule

// File: tb/tb_ntsc_sync_gen.sv
// Testbench for ntsc_sync_gen: a DIV=12 instance for divider/tick timing and
// a DIV=1 instance that walks a whole frame quickly for raster decoding.
// Honors NTSC_EQ_PULSES_EN when choosing expected sync levels on equalizing lines.
module tb_ntsc_sync_gen;

    localparam int LINE_TICKS  = 127;
    localparam int FRAME_TICKS = 262 * 127;

    logic clk;
    logic rst_n;

    logic       s_tick, s_row_enable, s_vblank, s_fetch_req, s_frame_start;
    logic [6:0] s_hcount;
    logic [8:0] s_line;
    logic [2:0] s_sync;
    logic [7:0] s_fetch_row;

    logic       f_tick, f_row_enable, f_vblank, f_fetch_req, f_frame_start;
    logic [6:0] f_hcount;
    logic [8:0] f_line;
    logic [2:0] f_sync;
    logic [7:0] f_fetch_row;

    int errors = 0;
    int checks = 0;
    int fetch_cnt = 0;
    int frame_cnt = 0;
    int re_cnt = 0;
    int low4_cnt = 0;

    ntsc_sync_gen #(.DIV(12)) dut_slow (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .tick        (s_tick),
        .hcount      (s_hcount),
        .line        (s_line),
        .row_enable  (s_row_enable),
        .vblank      (s_vblank),
        .sync_signal (s_sync),
        .fetch_req   (s_fetch_req),
        .fetch_row   (s_fetch_row),
        .frame_start (s_frame_start)
    );

    ntsc_sync_gen #(.DIV(1)) dut_fast (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .tick        (f_tick),
        .hcount      (f_hcount),
        .line        (f_line),
        .row_enable  (f_row_enable),
        .vblank      (f_vblank),
        .sync_signal (f_sync),
        .fetch_req   (f_fetch_req),
        .fetch_row   (f_fetch_row),
        .frame_start (f_frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, actual, expected);
        end
    endtask

    // Drive reset level, advance one clock and settle past the edge
    task automatic applyStimulus(input logic rst_val);
        rst_n = rst_val;
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_sync(input int l, input int h);
        bit low;
        if (l >= 3 && l <= 5)
            low = (h <= 53) || (h >= 63 && h <= 116);
`ifdef NTSC_EQ_PULSES_EN
        else if (l <= 2 || (l >= 6 && l <= 8))
            low = (h <= 4) || (h >= 63 && h <= 67);
`endif
        else
            low = (h <= 8);
        return low ? 0 : 1;
    endfunction

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_s_tick"}, s_tick, 0);
        checkOutput({tag, "_s_hcount"}, s_hcount, 0);
        checkOutput({tag, "_s_line"}, s_line, 0);
        checkOutput({tag, "_s_vblank"}, s_vblank, 1);
        checkOutput({tag, "_s_sync"}, s_sync, 1);
        checkOutput({tag, "_f_tick"}, f_tick, 0);
        checkOutput({tag, "_f_hcount"}, f_hcount, 0);
        checkOutput({tag, "_f_line"}, f_line, 0);
        checkOutput({tag, "_f_row_enable"}, f_row_enable, 0);
        checkOutput({tag, "_f_vblank"}, f_vblank, 1);
        checkOutput({tag, "_f_sync"}, f_sync, 1);
        checkOutput({tag, "_f_fetch_req"}, f_fetch_req, 0);
        checkOutput({tag, "_f_fetch_row"}, f_fetch_row, 0);
        checkOutput({tag, "_f_frame_start"}, f_frame_start, 0);
    endtask

    // n = number of clock edges since reset release; fast instance shows tick position n-1
    task automatic checkCycle(input int n);
        int  pos, h, l;
        bit  exp_fetch, exp_fs;
        if (n <= 49)
            checkOutput("slow_tick", s_tick, (n % 12 == 0) ? 1 : 0);
        if (n == 12 || n == 13 || n == 25 || n == 37 || n == 49)
            checkOutput("slow_hcount", s_hcount, (n - 1) / 12);

        pos = n - 1;
        h   = pos % LINE_TICKS;
        l   = (pos / LINE_TICKS) % 262;

        if (h == 0) begin
            checkOutput("fast_hcount", f_hcount, 0);
            checkOutput("fast_line", f_line, l);
        end
        if (l == 1 || l == 4 || l == 7 || l == 50)
            checkOutput($sformatf("sync_l%0d_h%0d", l, h), f_sync, exp_sync(l, h));
        if (l == 4 || l == 19 || l == 20 || l == 50 || l == 259 || l == 260) begin
            checkOutput($sformatf("row_en_l%0d_h%0d", l, h), f_row_enable,
                        (l >= 20 && l <= 259 && h >= 20 && h <= 123) ? 1 : 0);
            checkOutput($sformatf("vblank_l%0d", l), f_vblank, (l < 20 || l > 259) ? 1 : 0);
        end

        if (n <= FRAME_TICKS + 1) begin
            if (l == 50 && f_row_enable) re_cnt++;
            if (l == 4 && f_sync == 3'd0) low4_cnt++;
            if (f_fetch_req) fetch_cnt++;
            if (f_frame_start) frame_cnt++;
        end
        if (pos == 51 * LINE_TICKS - 1) checkOutput("line50_active_ticks", re_cnt, 104);
        if (pos == 5 * LINE_TICKS - 1) checkOutput("line4_low_ticks", low4_cnt, 108);

        exp_fetch = (n >= 2) && (h == 0) && (l >= 19) && (l <= 258);
        if (f_fetch_req || exp_fetch) begin
            checkOutput($sformatf("fetch_req_l%0d", l), f_fetch_req, exp_fetch);
            if (exp_fetch) checkOutput("fetch_row", f_fetch_row, l - 19);
        end
        if (n == 19 * LINE_TICKS + 1) checkOutput("first_fetch", f_fetch_req, 1);

        exp_fs = (n >= 2) && (pos % FRAME_TICKS == 0);
        if (f_frame_start || exp_fs)
            checkOutput("frame_start", f_frame_start, exp_fs);
        if (n == FRAME_TICKS + 1) begin
            checkOutput("frame_fetch_count", fetch_cnt, 240);
            checkOutput("frame_start_count", frame_cnt, 1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) applyStimulus(1'b0);
        checkResetState("reset");

        for (int n = 1; n <= FRAME_TICKS + 130 * LINE_TICKS + 61; n++) begin
            applyStimulus(1'b1);
            checkCycle(n);
        end
        checkOutput("pre_reset_line", f_line, 130);
        checkOutput("pre_reset_hcount", f_hcount, 60);

        applyStimulus(1'b0);
        checkResetState("mid_reset");
        applyStimulus(1'b0);
        checkOutput("hold_reset_f_tick", f_tick, 0);
        checkOutput("hold_reset_f_fetch", f_fetch_req, 0);

        for (int m = 1; m <= 13; m++) begin
            applyStimulus(1'b1);
            checkOutput("restart_slow_tick", s_tick, (m == 12) ? 1 : 0);
            if (m <= 3) begin
                checkOutput("restart_fast_hcount", f_hcount, m - 1);
                checkOutput("restart_fast_line", f_line, 0);
                checkOutput("restart_frame_start", f_frame_start, 0);
            end
            if (m == 13) checkOutput("restart_slow_hcount", s_hcount, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
